snake_body_scanner: RTL and testbench
=====================================

Name: snake_body_scanner

Overview:
- Upstream feeder of the graphic game stage.
- Holds the snake segment array and applies move/grow updates from the game FSM, but only while the graphic stage raises semaforo (its safe-update window).
- On request, streams the body segments one per clock as snake_body_x/snake_body_y/body_count, so the graphic stage can test each segment against the current block.
- Also drives snake_head_x/y and snake_length to that stage.

Parameters:
- SNAKE_LENGTH_BIT, 6, width of body_count.
- MAX_SEGMENTS, 15, maximum snake_length including the head (fits the 4-bit snake_length).
- COORD_BIT, 7, width of every block coordinate.

Ports:
- clock_25  in  1  25 MHz pixel clock.
- reset  in  1  synchronous, active-high.
- move_req  in  1  one-cycle pulse: advance snake to head_x/head_y.
- grow  in  1  sampled with move_req: lengthen by one on this move.
- head_x, head_y  in  COORD_BIT  new head block coordinates.
- semaforo  in  1  graphic stage update window; commits allowed only while 1.
- scan_start  in  1  pulse: begin streaming body segments.
- move_ack  out  1  one-cycle pulse: move committed.
- self_hit  out  1  registered: last committed head landed on a body segment.
- snake_head_x, snake_head_y  out  COORD_BIT  segment 0.
- snake_body_x, snake_body_y  out  COORD_BIT  currently streamed segment.
- body_count  out  SNAKE_LENGTH_BIT  index of the streamed segment.
- snake_length  out  4  segment count including the head.
- scan_busy  out  1  high while streaming is valid.
- scan_done  out  1  pulse, coincident with the last streamed segment.

Behaviour:
- Storage: seg[0..MAX_SEGMENTS-1] of {x,y}. seg[0] is the head. Valid segments are 0..snake_length-1.
- Reset values:
  - snake_length=3; seg[0]=(10,7), seg[1]=(9,7), seg[2]=(8,7); all other segments (0,0).
  - All other outputs 0. Pending move and pending scan cleared.
  - Reset mid-scan or mid-commit aborts it with no ack.
- move_req latching:
  - Latches head_x, head_y, grow into a pending-move register.
  - A second move_req while a move is pending overwrites the pending values (latest wins); only one ack is produced.
- FSM states IDLE, SCAN, COMMIT:
  - IDLE: if a move is pending and semaforo=1, go to COMMIT. Else if scan_start or a scan is pending, go to SCAN with body_count=1.
  - SCAN: one segment per clock. body_count runs 1..snake_length-1, snake_body_x/y=seg[body_count], scan_busy=1. On body_count=snake_length-1: scan_done=1, return to IDLE next cycle. scan_start during SCAN is ignored.
  - COMMIT (single cycle):
    - seg[i]<=seg[i-1] for i>=1; seg[0]<=pending head.
    - If grow and snake_length<MAX_SEGMENTS, snake_length+1. At MAX_SEGMENTS, grow is ignored and the tail drops.
    - Clear the pending move; move_ack=1 the next cycle; return to IDLE.
    - scan_start arriving in COMMIT is latched as a pending scan.
- Scan latency: scan_start at cycle t (FSM in IDLE, no committable move) gives body_count=1 at t+1 and scan_done at t+snake_length-1.
- Simultaneous events in IDLE: a committable move beats scan_start. The scan becomes pending and starts the cycle after COMMIT. This guarantees a scan never mixes pre- and post-move segments.
- Blocked commit: if semaforo=0, the move stays pending indefinitely. Scans proceed meanwhile.
- self_hit: registered at COMMIT. Set if the new head equals any old seg[0..L-2] (L = old length; tail excluded since it vacates), or seg[0..L-1] when growing. Held until the next commit.
- Outside SCAN: body_count=0 and snake_body_x/y hold their last values.
- Widths: body_count zero-extends the 4-bit index. Coordinates are passed unmodified; no wrap is applied here (boundary handled by the game FSM).

Decomposition:
- Shared package (snake_pkg):
  - COORD_BIT, SNAKE_LENGTH_BIT, MAX_SEGMENTS.
  - Reset snake constants (length 3, head (10,7)).
  - FSM state encoding.
- One natural sub-module: snake_hit_compare, the combinational comparator of a coordinate against the valid segment array, producing self_hit_next.

Test Plan:
- Reset, then scan_start → body_count 1,2; body (9,7),(8,7); scan_done with body_count=2; head (10,7); length 3.
- move_req head (11,7), grow=0, semaforo=1 → move_ack 2 cycles later; head (11,7), body (10,7),(9,7); length 3; self_hit=0.
- move_req (11,8) grow=1 with semaforo=0 for 20 cycles, then 1 → no ack until semaforo rises; then length 4, body (11,7),(10,7),(9,7).
- move_req and scan_start in the same cycle with semaforo=1 → COMMIT first; scan streams post-move segments only; scan_done after length-1 beats.
- Grow to 15, then move_req grow=1 → length stays 15, tail dropped; move_req onto seg[2] → self_hit=1; onto the vacated tail without grow → self_hit=0.
- Assert reset mid-scan at body_count=2 → scan_busy=0 next cycle, reset snake restored, no scan_done.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants, segment payload type and FSM encoding for the snake body scanner.
package snake_pkg;

    localparam int unsigned COORD_BIT        = 7;
    localparam int unsigned SNAKE_LENGTH_BIT = 6;
    localparam int unsigned MAX_SEGMENTS     = 15;
    localparam int unsigned LEN_BIT          = 4;

    localparam int unsigned RESET_LEN    = 3;
    localparam int unsigned RESET_HEAD_X = 10;
    localparam int unsigned RESET_HEAD_Y = 7;

    typedef struct packed {
        logic [COORD_BIT-1:0] x;
        logic [COORD_BIT-1:0] y;
    } seg_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Reset snake lies horizontally, head at (10,7), body trailing towards -x.
    function automatic seg_t reset_seg(input int unsigned idx);
        seg_t s;
        s = '0;
        if (idx < RESET_LEN) begin
            s.x = COORD_BIT'(RESET_HEAD_X - idx);
            s.y = COORD_BIT'(RESET_HEAD_Y);
        end
        return s;
    endfunction

endpackage

// File: rtl/snake_body_scanner_if.sv
// Game FSM / graphic stage side signals of the snake body scanner.
// master: drives move/scan requests and semaforo; slave: the scanner.
interface snake_body_scanner_if;
    import snake_pkg::*;

    logic                        move_req;
    logic                        grow;
    logic [COORD_BIT-1:0]        head_x;
    logic [COORD_BIT-1:0]        head_y;
    logic                        semaforo;
    logic                        scan_start;

    logic                        move_ack;
    logic                        self_hit;
    logic [COORD_BIT-1:0]        snake_head_x;
    logic [COORD_BIT-1:0]        snake_head_y;
    logic [COORD_BIT-1:0]        snake_body_x;
    logic [COORD_BIT-1:0]        snake_body_y;
    logic [SNAKE_LENGTH_BIT-1:0] body_count;
    logic [LEN_BIT-1:0]          snake_length;
    logic                        scan_busy;
    logic                        scan_done;

    modport master (
        output move_req, grow, head_x, head_y, semaforo, scan_start,
        input  move_ack, self_hit, snake_head_x, snake_head_y, snake_body_x,
               snake_body_y, body_count, snake_length, scan_busy, scan_done
    );

    modport slave (
        input  move_req, grow, head_x, head_y, semaforo, scan_start,
        output move_ack, self_hit, snake_head_x, snake_head_y, snake_body_x,
               snake_body_y, body_count, snake_length, scan_busy, scan_done
    );

endinterface

// File: rtl/snake_hit_compare.sv
// Combinational comparator of a candidate head against the segments it may collide with.
// i_segs: segment array, i_len: current length, i_grow: effective grow,
// i_x/i_y: candidate head, o_self_hit_next_c: collision flag.
module snake_hit_compare
    import snake_pkg::*;
(
    input  seg_t [MAX_SEGMENTS-1:0] i_segs,
    input  logic [LEN_BIT-1:0]      i_len,
    input  logic                    i_grow,
    input  logic [COORD_BIT-1:0]    i_x,
    input  logic [COORD_BIT-1:0]    i_y,
    output logic                    o_self_hit_next_c
);

    logic [LEN_BIT-1:0] w_span;

    // The tail vacates on a plain move, so it only counts when growing.
    always_comb begin
        w_span            = i_grow ? i_len : i_len - 1'b1;
        o_self_hit_next_c = 1'b0;
        for (int i = 0; i < MAX_SEGMENTS; i++) begin
            if ((LEN_BIT'(i) < w_span) && (i_segs[i].x == i_x) && (i_segs[i].y == i_y)) begin
                o_self_hit_next_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body_scanner.sv
// Holds the snake segment array, commits move/grow updates inside the semaforo
// window and streams body segments one per clock to the graphic stage.
// clock_25: pixel clock, reset: synchronous active-high, bus: request/stream signals.
module snake_body_scanner
    import snake_pkg::*;
(
    input  logic                 clock_25,
    input  logic                 reset,
    snake_body_scanner_if.slave  bus
);

    state_t                  r_state, w_state_next;
    seg_t [MAX_SEGMENTS-1:0] r_seg;
    logic [LEN_BIT-1:0]      r_len, r_idx, w_idx_next, w_last;
    logic                    r_pend_move, r_pend_grow, r_pend_scan;
    logic [COORD_BIT-1:0]    r_pend_x, r_pend_y, r_body_x, r_body_y;
    logic                    r_scan_busy, r_scan_done, r_move_ack, r_self_hit;
    logic                    w_commit, w_beat, w_scan_pend_set, w_scan_pend_clr;
    logic                    w_grow_eff, w_hit_next;

    assign w_last     = r_len - 1'b1;
    assign w_grow_eff = r_pend_grow && (r_len < LEN_BIT'(MAX_SEGMENTS));

    snake_hit_compare u_hit (
        .i_segs            (r_seg),
        .i_len             (r_len),
        .i_grow            (w_grow_eff),
        .i_x               (r_pend_x),
        .i_y               (r_pend_y),
        .o_self_hit_next_c (w_hit_next)
    );

    // Next state; an incoming move_req counts as pending so it beats a same-cycle scan_start.
    always_comb begin
        w_state_next    = r_state;
        w_commit        = 1'b0;
        w_beat          = 1'b0;
        w_idx_next      = r_idx;
        w_scan_pend_set = 1'b0;
        w_scan_pend_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_pend_move || bus.move_req) && bus.semaforo) begin
                    w_state_next    = ST_COMMIT;
                    w_scan_pend_set = bus.scan_start;
                end else if (bus.scan_start || r_pend_scan) begin
                    w_state_next    = ST_SCAN;
                    w_beat          = 1'b1;
                    w_idx_next      = LEN_BIT'(1);
                    w_scan_pend_clr = 1'b1;
                end
            end
            ST_SCAN: begin
                if (r_idx == w_last) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_beat     = 1'b1;
                    w_idx_next = r_idx + 1'b1;
                end
            end
            ST_COMMIT: begin
                w_commit        = 1'b1;
                w_state_next    = ST_IDLE;
                w_scan_pend_set = bus.scan_start;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= LEN_BIT'(RESET_LEN);
            r_idx       <= '0;
            r_pend_move <= 1'b0;
            r_pend_grow <= 1'b0;
            r_pend_scan <= 1'b0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_body_x    <= '0;
            r_body_y    <= '0;
            r_scan_busy <= 1'b0;
            r_scan_done <= 1'b0;
            r_move_ack  <= 1'b0;
            r_self_hit  <= 1'b0;
            for (int i = 0; i < MAX_SEGMENTS; i++) begin
                r_seg[i] <= reset_seg(32'(i));
            end
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_scan_busy <= w_beat;
            r_scan_done <= w_beat && (w_idx_next == w_last);
            r_move_ack  <= w_commit;
            if (w_beat) begin
                r_body_x <= r_seg[w_idx_next].x;
                r_body_y <= r_seg[w_idx_next].y;
            end
            // A move_req in the commit cycle becomes the next pending move.
            if (bus.move_req) begin
                r_pend_move <= 1'b1;
                r_pend_x    <= bus.head_x;
                r_pend_y    <= bus.head_y;
                r_pend_grow <= bus.grow;
            end else if (w_commit) begin
                r_pend_move <= 1'b0;
            end
            if (w_scan_pend_set) begin
                r_pend_scan <= 1'b1;
            end else if (w_scan_pend_clr) begin
                r_pend_scan <= 1'b0;
            end
            if (w_commit) begin
                for (int i = 1; i < MAX_SEGMENTS; i++) begin
                    r_seg[i] <= r_seg[i-1];
                end
                r_seg[0]   <= '{x: r_pend_x, y: r_pend_y};
                r_self_hit <= w_hit_next;
                if (w_grow_eff) begin
                    r_len <= r_len + 1'b1;
                end
            end
        end
    end

    assign bus.move_ack     = r_move_ack;
    assign bus.self_hit     = r_self_hit;
    assign bus.snake_head_x = r_seg[0].x;
    assign bus.snake_head_y = r_seg[0].y;
    assign bus.snake_body_x = r_body_x;
    assign bus.snake_body_y = r_body_y;
    assign bus.body_count   = SNAKE_LENGTH_BIT'(r_idx);
    assign bus.snake_length = r_len;
    assign bus.scan_busy    = r_scan_busy;
    assign bus.scan_done    = r_scan_done;

endmodule

// File: tb/tb_snake_body_scanner.sv
// Scoreboard bench for snake_body_scanner: drivers push expected acks/beats from a
// queue-based snake model, a negedge monitor pops and compares.
module tb_snake_body_scanner;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    snake_body_scanner_if bus();

    snake_body_scanner dut (
        .clock_25 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    typedef struct { int hx; int hy; int len; int hit; int cyc; } ack_t;
    typedef struct { int idx; int x; int y; int done; int cyc; } beat_t;

    ack_t  ack_q[$];
    beat_t beat_q[$];
    int    snk[$];          // model snake, element = x*128 + y, head first
    int    checks = 0, errors = 0;
    int    cyc = 0, ack_cnt = 0, done_cnt = 0, last_beat_cyc = 0;
    bit    mon_en = 1'b0;
    ack_t  m_ack;
    beat_t m_beat;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack and every streamed beat must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.move_ack === 1'b1) begin
                ack_cnt++;
                if (ack_q.size() == 0) begin
                    chk("unexpected_move_ack", 1, 0);
                end else begin
                    m_ack = ack_q.pop_front();
                    chk("ack_head_x", int'(bus.snake_head_x), m_ack.hx);
                    chk("ack_head_y", int'(bus.snake_head_y), m_ack.hy);
                    chk("ack_length", int'(bus.snake_length), m_ack.len);
                    chk("ack_self_hit", int'(bus.self_hit), m_ack.hit);
                    if (m_ack.cyc >= 0) chk("ack_latency", cyc, m_ack.cyc);
                end
            end
            if (bus.scan_busy === 1'b1) begin
                if (bus.scan_done === 1'b1) done_cnt++;
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    m_beat = beat_q.pop_front();
                    chk("beat_count", int'(bus.body_count), m_beat.idx);
                    chk("beat_x", int'(bus.snake_body_x), m_beat.x);
                    chk("beat_y", int'(bus.snake_body_y), m_beat.y);
                    chk("beat_done", int'(bus.scan_done), m_beat.done);
                    if (m_beat.cyc >= 0) chk("beat_latency", cyc, m_beat.cyc);
                    if (m_beat.idx != 1) chk("beat_contiguous", cyc, last_beat_cyc + 1);
                    last_beat_cyc = cyc;
                end
            end else begin
                chk("idle_body_count", int'(bus.body_count), 0);
                chk("idle_scan_done", int'(bus.scan_done), 0);
            end
        end
    end

    task automatic model_reset();
        snk.delete();
        snk.push_back(10*128 + 7);
        snk.push_back(9*128 + 7);
        snk.push_back(8*128 + 7);
    endtask

    // Apply a move to the model, returning whether the new head hits the body.
    function automatic int model_commit(input int x, input int y, input int g);
        int geff, span, hit;
        geff = (g != 0 && snk.size() < int'(MAX_SEGMENTS)) ? 1 : 0;
        span = (geff != 0) ? snk.size() : snk.size() - 1;
        hit  = 0;
        for (int j = 0; j < span; j++) if (snk[j] == x*128 + y) hit = 1;
        snk.push_front(x*128 + y);
        if (geff == 0) void'(snk.pop_back());
        return hit;
    endfunction

    task automatic expect_ack(input int x, input int y, input int g, input int c);
        ack_t e;
        e.hit = model_commit(x, y, g);
        e.hx  = x;
        e.hy  = y;
        e.len = snk.size();
        e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic expect_scan(input int c0);
        beat_t e;
        for (int k = 1; k < snk.size(); k++) begin
            e.idx  = k;
            e.x    = snk[k] / 128;
            e.y    = snk[k] % 128;
            e.done = (k == snk.size() - 1) ? 1 : 0;
            e.cyc  = (c0 < 0) ? -1 : c0 + k;
            beat_q.push_back(e);
        end
    endtask

    task automatic wait_acks(input int target);
        for (int i = 0; i < 300 && ack_cnt < target; i++) step();
        chk("ack_arrived", ack_cnt, target);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && done_cnt < target; i++) step();
        chk("scan_done_arrived", done_cnt, target);
    endtask

    task automatic drive_move(input int x, input int y, input int g);
        bus.head_x   = COORD_BIT'(x);
        bus.head_y   = COORD_BIT'(y);
        bus.grow     = g[0];
        bus.move_req = 1'b1;
    endtask

    task automatic op_move(input int x, input int y, input int g);
        int t;
        t = ack_cnt + 1;
        expect_ack(x, y, g, cyc + 2);
        drive_move(x, y, g);
        step();
        bus.move_req = 1'b0;
        wait_acks(t);
    endtask

    task automatic op_scan();
        int t;
        t = done_cnt + 1;
        expect_scan(cyc);
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        wait_done(t);
    endtask

    task automatic op_move_scan(input int x, input int y, input int g);
        int ta, td;
        ta = ack_cnt + 1;
        td = done_cnt + 1;
        expect_ack(x, y, g, cyc + 2);
        expect_scan(-1);
        drive_move(x, y, g);
        bus.scan_start = 1'b1;
        step();
        bus.move_req   = 1'b0;
        bus.scan_start = 1'b0;
        wait_acks(ta);
        wait_done(td);
    endtask

    task automatic op_blocked(input int x, input int y, input int g, input int hold,
                              input int second, input int x2, input int y2, input int g2,
                              input int scan_mid);
        int ta, fx, fy, fg;
        ta = ack_cnt;
        fx = x; fy = y; fg = g;
        bus.semaforo = 1'b0;
        drive_move(x, y, g);
        step();
        bus.move_req = 1'b0;
        if (second != 0) begin
            step();
            drive_move(x2, y2, g2);
            step();
            bus.move_req = 1'b0;
            fx = x2; fy = y2; fg = g2;
        end
        if (scan_mid != 0) op_scan();
        repeat (hold) step();
        chk("blocked_no_ack", ack_cnt, ta);
        expect_ack(fx, fy, fg, cyc + 2);
        bus.semaforo = 1'b1;
        wait_acks(ta + 1);
    endtask

    task automatic op_reset_mid_scan();
        int    td;
        beat_t e;
        td = done_cnt;
        for (int k = 1; k <= 2; k++) begin
            e.idx  = k;
            e.x    = snk[k] / 128;
            e.y    = snk[k] % 128;
            e.done = (k == snk.size() - 1) ? 1 : 0;
            e.cyc  = cyc + k;
            beat_q.push_back(e);
        end
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_scan_busy", int'(bus.scan_busy), 0);
        chk("rst_length", int'(bus.snake_length), 3);
        chk("rst_head_x", int'(bus.snake_head_x), 10);
        chk("rst_head_y", int'(bus.snake_head_y), 7);
        chk("rst_no_scan_done", done_cnt, td);
        step();
        rst = 1'b0;
        model_reset();
        step();
        chk("rst_busy_after", int'(bus.scan_busy), 0);
    endtask

    task automatic pick(output int x, output int y);
        int v;
        if ($urandom_range(0, 2) == 0) begin
            v = snk[$urandom_range(0, snk.size() - 1)];
            x = v / 128;
            y = v % 128;
        end else begin
            x = int'($urandom_range(0, 20));
            y = int'($urandom_range(0, 20));
        end
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int x, y, x2, y2, v;
        bus.move_req   = 1'b0;
        bus.grow       = 1'b0;
        bus.head_x     = '0;
        bus.head_y     = '0;
        bus.semaforo   = 1'b1;
        bus.scan_start = 1'b0;
        model_reset();
        repeat (3) step();
        mon_en = 1'b1;
        rst = 1'b0;
        step();

        chk("reset_head_x", int'(bus.snake_head_x), 10);
        chk("reset_head_y", int'(bus.snake_head_y), 7);
        chk("reset_length", int'(bus.snake_length), 3);
        chk("reset_move_ack", int'(bus.move_ack), 0);
        chk("reset_self_hit", int'(bus.self_hit), 0);
        chk("reset_scan_busy", int'(bus.scan_busy), 0);
        chk("reset_body_x", int'(bus.snake_body_x), 0);

        op_scan();
        op_move(11, 7, 0);
        chk("move1_head_x", int'(bus.snake_head_x), 11);
        chk("move1_length", int'(bus.snake_length), 3);
        chk("move1_self_hit", int'(bus.self_hit), 0);
        op_scan();

        op_blocked(11, 8, 1, 20, 0, 0, 0, 0, 0);
        chk("blocked_length", int'(bus.snake_length), 4);
        op_scan();

        op_move_scan(12, 8, 0);

        while (snk.size() < int'(MAX_SEGMENTS)) op_move(snk[0] / 128 + 1, snk[0] % 128, 1);
        op_move(snk[0] / 128 + 1, snk[0] % 128, 1);
        chk("length_cap", int'(bus.snake_length), 15);
        op_scan();
        v = snk[2];
        op_move(v / 128, v % 128, 0);
        chk("hit_seg2", int'(bus.self_hit), 1);
        v = snk[snk.size() - 1];
        op_move(v / 128, v % 128, 0);
        chk("tail_vacated", int'(bus.self_hit), 0);

        op_reset_mid_scan();

        for (int n = 0; n < 80; n++) begin
            pick(x, y);
            case ($urandom_range(0, 3))
                0: op_move(x, y, int'($urandom_range(0, 1)));
                1: op_scan();
                2: op_move_scan(x, y, int'($urandom_range(0, 1)));
                default: begin
                    pick(x2, y2);
                    op_blocked(x, y, int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                               int'($urandom_range(0, 1)), x2, y2, int'($urandom_range(0, 1)),
                               int'($urandom_range(0, 1)));
                end
            endcase
        end
        op_scan();

        repeat (5) step();
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("beat_queue_drained", beat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
